// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU memory port.
// It uses a req/ack handshake with WAIT_CYCLES wait states between capture
// and response. The RAM is word-addressed and has byte-lane write enables.
// Accesses outside the RAM are flagged with AddrErr. They never alias.
// Optional build macro: MEM_ALIGN_CHECK_EN. When defined, any access with a
// nonzero Address[1:0] is rejected in the same way as an out-of-range access.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] MemData,
  output logic        Ack,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] LOAD = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_wr;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_memdata;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_ram [DEPTH];

  logic          w_capture;
  logic          w_to_resp;
  logic          w_cap_wr;
  logic          w_cap_err;
  logic [31:0]   w_cap_addr;
  logic [AW-1:0] w_cap_idx;
  logic [AW-1:0] w_idx;
  logic          w_unused_lsb;

  // An address is rejected when it lies beyond the RAM. With the alignment
  // check built in, an address that is not word-aligned is also rejected.
  function automatic logic f_addr_err(input logic [31:0] a);
    logic e;
    e = |a[31:AW+2];
`ifdef MEM_ALIGN_CHECK_EN
    e = e | (|a[1:0]);
`endif
    return e;
  endfunction

  // With zero wait states the response is entered on the capture edge itself.
  // The transaction view therefore selects the live inputs while in IDLE and
  // the captured copy afterwards.
  assign w_capture    = (r_state == S_IDLE) && Req;
  assign w_to_resp    = (w_capture && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_cap_addr   = (r_state == S_IDLE) ? Address : r_addr;
  assign w_cap_wr     = (r_state == S_IDLE) ? Wr : r_wr;
  assign w_cap_idx    = w_cap_addr[AW+1:2];
  assign w_cap_err    = f_addr_err(w_cap_addr);
  assign w_idx        = r_addr[AW+1:2];
  assign w_unused_lsb = ^w_cap_addr[1:0];

  // Control FSM. Ack, AddrErr and read data are loaded on entry to RESP.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_memdata <= 32'd0;
    end else begin
      r_ack <= w_to_resp;
      r_err <= w_to_resp && w_cap_err;
      if (w_to_resp && !w_cap_wr)
        r_memdata <= w_cap_err ? 32'd0 : r_ram[w_cap_idx];
      case (r_state)
        S_IDLE: begin
          if (Req) begin
            r_cnt   <= LOAD;
            r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1)
            r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request capture. This is data only, so it has no reset.
  always_ff @(posedge Clk) begin
    if (w_capture) begin
      r_wr    <= Wr;
      r_addr  <= Address;
      r_wdata <= WriteData;
      r_be    <= ByteEn;
    end
  end

  // Store commit on the edge that leaves RESP. A reset at that edge drops it.
  always_ff @(posedge Clk) begin
    if (Reset && (r_state == S_RESP) && r_wr && !r_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i])
          r_ram[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign MemData = r_memdata;
  assign Ack     = r_ack;
  assign AddrErr = r_err;
  assign Busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder. Instance 0 uses
// WAIT_CYCLES=2 and instance 1 uses WAIT_CYCLES=0. Both use DEPTH=256 and are
// checked against a word-array reference model.
module tb_mem_responder;

  logic        Clk;
  logic        Reset;
  logic        req  [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [3:0]  be   [2];
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        busy [2];
  logic        err  [2];

  int          errors;
  int          checks;
  logic [31:0] mdl     [2][256];
  logic [31:0] last_rd [2];

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Req(req[0]), .Wr(wr[0]), .Address(addr[0]),
    .WriteData(wdat[0]), .ByteEn(be[0]), .MemData(rdat[0]), .Ack(ack[0]),
    .Busy(busy[0]), .AddrErr(err[0])
  );

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Req(req[1]), .Wr(wr[1]), .Address(addr[1]),
    .WriteData(wdat[1]), .ByteEn(be[1]), .MemData(rdat[1]), .Ack(ack[1]),
    .Busy(busy[1]), .AddrErr(err[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The model rejects addresses at or beyond 1 KiB. With the alignment check
  // built in, it also rejects unaligned addresses.
  function automatic logic exp_err(input logic [31:0] a);
    logic e;
    e = (a >= 32'd1024);
`ifdef MEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  // Runs one transaction on instance i and checks latency, Busy, AddrErr and
  // data. When glitch is set, a stray Req is pulsed while the instance is busy.
  task automatic txn(input int i, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, input bit glitch);
    logic [31:0] erd;
    logic [31:0] got;
    logic        eerr;
    logic        gerr;
    int          lat;
    int          busyc;
    int          wc;
    wc   = (i == 0) ? 2 : 0;
    eerr = exp_err(a);
    if (w) erd = last_rd[i];
    else   erd = eerr ? 32'd0 : mdl[i][a[9:2]];
    @(negedge Clk);
    req[i] = 1'b1; wr[i] = w; addr[i] = a; wdat[i] = d; be[i] = b;
    @(posedge Clk); #1;
    req[i] = 1'b0;
    lat = 0; busyc = 0; got = 'x; gerr = 'x;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (busy[i]) busyc++;
      if (ack[i]) begin
        lat  = n;
        got  = rdat[i];
        gerr = err[i];
      end else begin
        chk("addrerr_without_ack", {31'd0, err[i]}, 32'd0);
        if (glitch && n == 1) begin
          req[i] = 1'b1; addr[i] = a ^ 32'h4; wr[i] = ~w;
        end
        @(posedge Clk); #1;
        req[i] = 1'b0;
      end
    end
    chk("ack_latency", lat, wc + 1);
    chk("busy_cycles", busyc, wc + 1);
    chk("addrerr", {31'd0, gerr}, {31'd0, eerr});
    chk(w ? "memdata_on_store" : "read_data", got, erd);
    @(posedge Clk); #1;
    chk("busy_after_resp", {31'd0, busy[i]}, 32'd0);
    chk("ack_one_cycle", {31'd0, ack[i]}, 32'd0);
    if (w && !eerr) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) mdl[i][a[9:2]][8*k +: 8] = d[8*k +: 8];
    end
    if (!w) last_rd[i] = erd;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] keep;
    errors = 0; checks = 0;
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdat[i] = '0; be[i] = '0;
      last_rd[i] = 32'd0;
    end

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ack", {31'd0, ack[i]}, 32'd0);
      chk("reset_busy", {31'd0, busy[i]}, 32'd0);
      chk("reset_addrerr", {31'd0, err[i]}, 32'd0);
      chk("reset_memdata", rdat[i], 32'd0);
    end
    Reset = 1'b1;

    // Fill words 0..15 of both instances with known random values
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++)
        txn(i, 1'b1, 32'(j * 4), $urandom, 4'hF, 1'b0);

    // Directed full store/read with a stray Req during WAIT
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    chk("read_direct", last_rd[0], 32'hDEADBEEF);
    @(negedge Clk);
    chk("memdata_held", rdat[0], 32'hDEADBEEF);

    // Byte lanes and empty enables
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    chk("byte_lanes", last_rd[0], 32'hDE22BE44);
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    chk("byteen_zero", last_rd[0], 32'hDE22BE44);

    // Out of range
    txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0);
    chk("oor_read_zero", last_rd[0], 32'd0);
    keep = mdl[0][0];
    txn(0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 1'b0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    chk("oor_store_no_alias", last_rd[0], keep);

    // Unaligned read, which is rejected only when the alignment check is built in
    txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("unaligned_read", last_rd[0], 32'd0);
`else
    chk("unaligned_read", last_rd[0], 32'hDE22BE44);
`endif

    // Zero wait states with Req held high: Ack in cycles 1, 3, 5
    @(negedge Clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h10;
    for (int n = 1; n <= 6; n++) begin
      @(posedge Clk); #1;
      chk("held_req_ack", {31'd0, ack[1]}, 32'(n % 2));
      if (ack[1]) chk("held_req_data", rdat[1], mdl[1][4]);
    end
    req[1] = 1'b0;
    last_rd[1] = mdl[1][4];

    // Reset during WAIT abandons a store
    @(negedge Clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h14; wdat[0] = ~mdl[0][5]; be[0] = 4'hF;
    @(posedge Clk); #1;
    req[0] = 1'b0;
    chk("busy_in_wait", {31'd0, busy[0]}, 32'd1);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    chk("midreset_busy", {31'd0, busy[0]}, 32'd0);
    chk("midreset_memdata", rdat[0], 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    for (int n = 0; n < 5; n++) begin
      chk("midreset_no_ack", {31'd0, ack[0]}, 32'd0);
      @(posedge Clk); #1;
    end
    txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0);

    // Random traffic on both instances
    for (int t = 0; t < 80; t++) begin
      int i;
      i = (t % 3 == 0) ? 1 : 0;
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      txn(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
